uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- UART receive frame engine, the far end of the TX serializer/parity path.
- Oversamples rx_in, detects the start edge and majority-samples each bit.
- Deserializes LSB-first data, checks parity (same rule as the TX parity calculator) and checks the stop bit.
- Presents a parallel word with a one-cycle valid pulse or error flags to the RX register/FIFO layer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input and the per-bit edge counter.

Ports:
- clk  input  1  system clock, running at prescale x baud.
- rst  input  1  synchronous, active-low reset.
- rx_in  input  1  serial line, idle high.
- prescale  input  PRESCALE_WIDTH  oversampling ratio P; even values 8..32 supported; latched at start detection.
- par_en  input  1  1 = frame carries a parity bit; latched at start detection.
- par_typ  input  1  0 = even, 1 = odd; latched at start detection.
- data_out  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse; data_out updated this cycle.
- par_err  output  1  one-cycle pulse at end of a frame with a parity mismatch.
- stp_err  output  1  one-cycle pulse at end of a frame with a stop bit sampled 0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE; counters cleared.
  - data_out=0, data_valid=0, par_err=0, stp_err=0.
  - Previous-line register set to 1.
  - Applies mid-frame too: the partial frame is discarded with no flags.
- Edge counter: counts 0..P-1 within each bit period and wraps to 0 at P-1 while bit_cnt increments. Cycle 0 of the start bit is the cycle IDLE detects the edge.
- Sampling: rx_in is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples, registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on rx_in=0 with previous rx_in=1 (falling edge only). A line held low never retriggers.
  - START: majority evaluated at edge_cnt=P/2+1. If 1 (glitch), return to IDLE with no flags. Otherwise stay in START until edge_cnt=P-1, then go to DATA.
  - DATA: DATA_WIDTH bits, LSB first, shifted into a holding register at each majority point. After bit DATA_WIDTH-1 ends, go to PARITY if par_en=1, else STOP.
  - PARITY: store the received parity bit, then go to STOP at the end of the bit.
  - STOP: at edge_cnt=P/2+1 the majority is evaluated and the FSM returns directly to IDLE, half a bit early, so a back-to-back start edge is caught.
- Parity rule:
  - expected = XOR-reduce(data) XOR par_typ.
  - Mismatch against the received bit -> par_err.
  - Not checked when par_en=0.
- End of frame: the cycle after STOP evaluation, exactly one of these occurs:
  - No errors: data_valid=1 and data_out loads the holding register.
  - One or both errors: par_err and/or stp_err = 1 together; data_valid=0 and data_out is unchanged.
- Latency: with P=8 and start edge at cycle 0, data_valid occurs at cycle 86 with parity and cycle 78 without.
- Configuration changes mid-frame have no effect until the next start edge.
- P < 8 or odd P: behaviour undefined; not verified.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx_in passes through a 2-flop synchronizer (reset value 1) before edge detection and sampling. All latencies increase by 2 cycles, measured from rx_in.
- Undefined: rx_in is used directly; the integrator guarantees it is synchronous to clk.

Test Plan:
1. P=8, par_en=1, par_typ=0, frame 0xA5 with parity bit 0 and stop bit 1 -> data_valid at cycle 86, data_out=0xA5, no error flags.
2. P=16, par_en=1, par_typ=1, byte 0x3C sent with parity bit 0 (expected 1) -> par_err pulses 1 cycle, data_valid=0, data_out keeps its prior value.
3. P=8, par_en=0, byte 0x81, stop bit driven 0 -> stp_err at cycle 78; line then held low for 40 cycles -> no new frame until rx_in returns to 1 and falls again.
4. 2-cycle low glitch on idle line, P=8 -> FSM back to IDLE by cycle 6, no outputs; the following valid frame 0x5A is received correctly.
5. Two back-to-back frames 0x12 then 0xEF, P=32, parity even -> two data_valid pulses with correct words; the second start edge is detected.
6. rst=0 asserted during DATA bit 4, released -> all outputs 0, FSM IDLE, next frame 0x77 received cleanly; repeat with UART_RX_SYNC_EN defined -> same data, data_valid 2 cycles later.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detection, 3-sample majority per bit,
// LSB-first data, optional parity and stop check. Define UART_RX_SYNC_EN to add a 2-flop rx_in synchronizer.
module uart_rx_deframer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx_in};
  end
  assign rx = sync[1];
`else
  assign rx = rx_in;
`endif

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt, p_l;
  logic [BCW-1:0]            bit_cnt;
  logic                      pe_l, pt_l, prev, s0, s1;
  logic                      par_bit, stop_bit, done;
  logic [DATA_WIDTH-1:0]     shreg;

  logic [PRESCALE_WIDTH-1:0] half, samp0, samp2, last;
  logic                      maj, bit_end, par_bad;

  assign half    = {1'b0, p_l[PRESCALE_WIDTH-1:1]};
  assign samp0   = half - PRESCALE_WIDTH'(1);
  assign samp2   = half + PRESCALE_WIDTH'(1);
  assign last    = p_l - PRESCALE_WIDTH'(1);
  // Third sample is the live line, so the majority is ready on the third sampling cycle.
  assign maj     = (s0 & s1) | (s0 & rx) | (s1 & rx);
  assign bit_end = (edge_cnt == last);
  assign par_bad = pe_l & ((^shreg) ^ pt_l ^ par_bit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_l        <= '0;
      pe_l       <= 1'b0;
      pt_l       <= 1'b0;
      prev       <= 1'b1;
      s0         <= 1'b1;
      s1         <= 1'b1;
      par_bit    <= 1'b0;
      stop_bit   <= 1'b1;
      done       <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      prev       <= rx;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      done       <= 1'b0;

      // Frame verdict lands one cycle after the stop evaluation, overlapping IDLE.
      if (done) begin
        if (par_bad || !stop_bit) begin
          par_err <= par_bad;
          stp_err <= !stop_bit;
        end else begin
          data_valid <= 1'b1;
          data_out   <= shreg;
        end
      end

      if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
        if (edge_cnt == samp0) s0 <= rx;
        if (edge_cnt == half)  s1 <= rx;
      end

      case (state)
        IDLE: if (!rx && prev) begin
          state    <= START;
          edge_cnt <= PRESCALE_WIDTH'(1);
          bit_cnt  <= '0;
          p_l      <= prescale;
          pe_l     <= par_en;
          pt_l     <= par_typ;
        end
        START: begin
          if (edge_cnt == samp2 && maj) state <= IDLE;
          else if (bit_end)             state <= DATA;
        end
        DATA: begin
          if (edge_cnt == samp2) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          if (bit_end) begin
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_WIDTH-1)) state <= pe_l ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (edge_cnt == samp2) par_bit <= maj;
          if (bit_end)           state   <= STOP;
        end
        STOP: if (edge_cnt == samp2) begin
          // Leave half a bit early so a back-to-back start edge is seen.
          stop_bit <= maj;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames push expected events,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_uart_rx_deframer;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, par_err, stp_err;

  uart_rx_deframer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .data_out(data_out),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         valid;
    bit         pe;
    bit         se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: dv=%0b pe=%0b se=%0b data=%02h at cycle %0d, nothing expected",
                 data_valid, par_err, stp_err, data_out, cyc);
      end else begin
        mon_e = q.pop_front();
        check("data_valid", 32'(data_valid), 32'(mon_e.valid));
        check("par_err",    32'(par_err),    32'(mon_e.pe));
        check("stp_err",    32'(stp_err),    32'(mon_e.se));
        check("data_out",   32'(data_out),   32'(mon_e.data));
        check("event_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Drives one frame; leaves the line at the stop value with one stop cycle still to run,
  // which the next call's leading posedge wait completes. lat < 0 means no expectation.
  task automatic send_frame(input int p, input logic [7:0] d, input bit pe, input bit pt,
                            input bit pbit, input bit sbit, input int lat,
                            input bit ev, input bit epe, input bit ese, input logic [7:0] edata);
    exp_t e;
    @(posedge clk); #1;
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    rx_in    = 1'b0;
    if (lat >= 0) begin
      e.valid = ev; e.pe = epe; e.se = ese; e.data = edata;
      e.cyc   = cyc + 1 + lat + SYNC_LAT;
      q.push_back(e);
    end
    repeat (p) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_in = d[i];
      repeat (p) @(posedge clk);
    end
    if (pe) begin
      #1 rx_in = pbit;
      repeat (p) @(posedge clk);
    end
    #1 rx_in = sbit;
    repeat (p - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1 rx_in = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out",   32'(data_out),   32'h0);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_par_err",    32'(par_err),    32'h0);
    check("reset_stp_err",    32'(stp_err),    32'h0);
    @(posedge clk); #1 rst = 1'b1;
    idle(5);

    // 1: P=8, even parity, 0xA5 -> valid at 86
    send_frame(8, 8'hA5, 1, 0, 0, 1, 86, 1, 0, 0, 8'hA5);
    idle(10);

    // 2: P=16, odd parity, 0x3C with wrong parity bit 0 -> par_err, data_out held
    send_frame(16, 8'h3C, 1, 1, 0, 1, 170, 0, 1, 0, 8'hA5);
    idle(10);

    // 3: P=8, no parity, 0x81, stop 0 -> stp_err at 78; line stays low, no retrigger
    send_frame(8, 8'h81, 0, 0, 0, 0, 78, 0, 0, 1, 8'hA5);
    repeat (40) @(posedge clk);
    idle(10);

    // 4: 2-cycle glitch, then 0x5A without parity
    @(posedge clk); #1 rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8, 8'h5A, 0, 0, 0, 1, 78, 1, 0, 0, 8'h5A);
    idle(10);

    // 5: back-to-back at P=32, even parity
    send_frame(32, 8'h12, 1, 0, 0, 1, 338, 1, 0, 0, 8'h12);
    send_frame(32, 8'hEF, 1, 0, 1, 1, 338, 1, 0, 0, 8'hEF);
    idle(10);

    // 6: reset during data bit 4, held until the aborted frame ends
    fork
      send_frame(8, 8'h77, 1, 0, 0, 1, -1, 0, 0, 0, 8'h00);
      begin
        @(posedge clk); #1;
        repeat (44) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    @(negedge clk);
    check("midrst_data_out",   32'(data_out),   32'h0);
    check("midrst_data_valid", 32'(data_valid), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("postrst_data_out", 32'(data_out), 32'h0);
    check("postrst_par_err",  32'(par_err),  32'h0);
    check("postrst_stp_err",  32'(stp_err),  32'h0);
    send_frame(8, 8'h77, 1, 0, 0, 1, 86, 1, 0, 0, 8'h77);
    idle(5);

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
